axi4_lite_wr_reg_slave: RTL and testbench



---
 rtl/axi4_lite_wr_reg_slave.sv | 190 +++++++++++++++++++
 tb/tb_axi4_lite_wr_reg_slave.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_wr_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_wr_reg_slave
// Purpose  : AXI4-Lite write-only endpoint. Terminates the AW, W and B
//            channels and accepts AW and W in either order, or together in
//            one cycle. Each channel has a one-entry holding register.
//            When both entries are full and the B slot can take a response,
//            the write is committed into a local register bank. Only the
//            bytes selected by the write strobes change. In-range addresses
//            return OKAY; all other addresses return SLVERR.
// Ports    : aclk_i      - clock
//            aresetn_i   - asynchronous active-low reset
//            awvalid_i / awready_o / awaddr_i       - write address channel
//            wvalid_i / wready_o / wdata_i / wstrb_i - write data channel
//            bvalid_o / bready_i / bresp_o           - write response channel
//            reg_q_o     - register bank; register k at [k*8N +: 8N]
//            wr_pulse_o  - one-cycle pulse per register on a committed write
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_wr_reg_slave #(
  parameter int          A    = 32,
  parameter int          N    = 4,
  parameter int          NREG = 16,
  parameter logic [A-1:0] BASE = '0
) (
  input  logic                  aclk_i,
  input  logic                  aresetn_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [A-1:0]          awaddr_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [8*N-1:0]        wdata_i,
  input  logic [N-1:0]          wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  output logic [NREG*8*N-1:0]   reg_q_o,
  output logic [NREG-1:0]       wr_pulse_o
);

  localparam int DW = 8 * N;
  localparam int LG = $clog2(N);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bit 0 of the state is the AW-held flag and bit 1 is the W-held flag.
  // This lets each ready come straight from a single state flop.
  localparam logic [1:0] S_EMPTY   = 2'b00;
  localparam logic [1:0] S_HAVE_AW = 2'b01;
  localparam logic [1:0] S_HAVE_W  = 2'b10;
  localparam logic [1:0] S_BOTH    = 2'b11;

  logic [1:0]      state_q, state_d;
  logic            aw_hs, w_hs, commit;

  logic [A-1:0]    awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [N-1:0]    wstrb_q;

  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;

  logic [DW-1:0]   bank_q [NREG];
  logic [NREG-1:0] hit;
  logic [NREG-1:0] wr_pulse_q;

  logic [A-1:0]    off, idx;
  logic            in_range;

  // --------------------------------------------------------------------------
  // Hold FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Hold FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (aw_hs && w_hs) state_d = S_BOTH;
        else if (aw_hs)    state_d = S_HAVE_AW;
        else if (w_hs)     state_d = S_HAVE_W;
      end
      S_HAVE_AW: if (w_hs)   state_d = S_BOTH;
      S_HAVE_W:  if (aw_hs)  state_d = S_BOTH;
      S_BOTH:    if (commit) state_d = S_EMPTY;
      default:   state_d = S_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Hold FSM: outputs and commit
  // A commit is allowed when the B slot is free or is being drained on this
  // edge. This gives back-to-back responses with no bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    awready_o = ~state_q[0];
    wready_o  = ~state_q[1];
    aw_hs     = awvalid_i & ~state_q[0];
    w_hs      = wvalid_i  & ~state_q[1];
    commit    = (state_q == S_BOTH) & (~bvalid_q | bready_i);

    bvalid_d  = bvalid_q & ~bready_i;
    bresp_d   = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // --------------------------------------------------------------------------
  // Address decode
  // The low LG address bits are shifted out, so unaligned addresses select
  // the register that contains them. The awaddr_q >= BASE term catches
  // addresses below BASE, which wrap around to a large offset.
  // --------------------------------------------------------------------------
  always_comb begin
    off      = awaddr_q - BASE;
    idx      = off >> LG;
    in_range = (awaddr_q >= BASE) && (idx < A'(NREG));
    hit      = '0;
    for (int k = 0; k < NREG; k++) begin
      hit[k] = commit & in_range & (idx == A'(k));
    end
  end

  // --------------------------------------------------------------------------
  // Holding registers and B channel
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      if (aw_hs) awaddr_q <= awaddr_i;
      if (w_hs) begin
        wdata_q <= wdata_i;
        wstrb_q <= wstrb_i;
      end
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= hit;
    end
  end

  // --------------------------------------------------------------------------
  // Register bank with byte-lane write enables
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int k = 0; k < NREG; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (hit[k]) begin
          for (int b = 0; b < N; b++) begin
            if (wstrb_q[b]) bank_q[k][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  generate
    for (genvar k = 0; k < NREG; k++) begin : g_out
      assign reg_q_o[k*DW +: DW] = bank_q[k];
    end
  endgenerate

  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign wr_pulse_o = wr_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_wr_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_wr_reg_slave
// Purpose  : Self-checking bench for axi4_lite_wr_reg_slave. When a write is
//            driven, its expected B response and wr_pulse are pushed into
//            scoreboards. A negedge monitor pops and compares them as the
//            DUT produces them. A shadow model of the bank checks reg_q.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_wr_reg_slave;

  localparam int A    = 32;
  localparam int N    = 4;
  localparam int NREG = 16;
  localparam logic [A-1:0] BASE = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              awvalid = 1'b0, awready;
  logic [A-1:0]      awaddr = '0;
  logic              wvalid = 1'b0, wready;
  logic [8*N-1:0]    wdata = '0;
  logic [N-1:0]      wstrb = '0;
  logic              bvalid, bready = 1'b1;
  logic [1:0]        bresp;
  logic [NREG*8*N-1:0] reg_q;
  logic [NREG-1:0]   wr_pulse;

  always #5 clk = ~clk;

  axi4_lite_wr_reg_slave #(.A(A), .N(N), .NREG(NREG), .BASE(BASE)) u_dut (
    .aclk_i     (clk),
    .aresetn_i  (rst_n),
    .awvalid_i  (awvalid),
    .awready_o  (awready),
    .awaddr_i   (awaddr),
    .wvalid_i   (wvalid),
    .wready_o   (wready),
    .wdata_i    (wdata),
    .wstrb_i    (wstrb),
    .bvalid_o   (bvalid),
    .bready_i   (bready),
    .bresp_o    (bresp),
    .reg_q_o    (reg_q),
    .wr_pulse_o (wr_pulse)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [1:0]      exp_b_q [$];
  logic [NREG-1:0] exp_p_q [$];
  int              b_times [$];
  logic [31:0]     model   [NREG];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rq(input int k);
    return reg_q[k*32 +: 32];
  endfunction

  // Monitor: a B handshake or a pulse seen at a negedge is taken on the next posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) check_val("b_unexpected", 32'(exp_b_q.size()), 32'd1);
        else check_val("bresp", {30'd0, bresp}, {30'd0, exp_b_q.pop_front()});
        b_times.push_back(cyc);
      end
      if (wr_pulse != '0) begin
        if (exp_p_q.size() == 0) check_val("pulse_unexpected", {16'd0, wr_pulse}, 32'd0);
        else check_val("wr_pulse", {16'd0, wr_pulse}, {16'd0, exp_p_q.pop_front()});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] off;
    int unsigned idx;
    off = addr - BASE;
    idx = off >> 2;
    if (addr >= BASE && idx < NREG) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
      exp_b_q.push_back(2'b00);
      exp_p_q.push_back(NREG'(1) << idx);
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) sync();
    awvalid = 1'b1;
    awaddr  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    sync();
    awvalid = 1'b0;
    check_val("aw_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
    logic ok;
    ok = 1'b0;
    repeat (dly) sync();
    wvalid = 1'b1;
    wdata  = data;
    wstrb  = strb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    sync();
    wvalid = 1'b0;
    check_val("w_handshake", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly);
    expect_write(addr, data, strb);
    fork
      send_aw(addr, aw_dly);
      send_w(data, strb, w_dly);
    join
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_b_q.size() == 0 && exp_p_q.size() == 0) break;
    end
    check_val("drain", 32'(exp_b_q.size() + exp_p_q.size()), 32'd0);
    @(negedge clk);
    sync();
  endtask

  task automatic check_bank(input string tag);
    for (int k = 0; k < NREG; k++) check_val(tag, rq(k), model[k]);
  endtask

  initial begin
    logic [31:0] old4;
    for (int k = 0; k < NREG; k++) model[k] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_awready", {31'd0, awready}, 32'd1);
    check_val("rst_wready",  {31'd0, wready},  32'd1);
    check_val("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check_val("rst_bresp",   {30'd0, bresp},   32'd0);
    check_val("rst_pulse",   {16'd0, wr_pulse}, 32'd0);
    check_bank("rst_reg");
    @(negedge clk);
    rst_n = 1'b1;
    sync();

    // AW first, W two cycles later
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 2);
    @(negedge clk);
    check_val("aw_held_low", {31'd0, awready}, 32'd0);
    @(negedge clk);
    check_val("aw_reassert", {31'd0, awready}, 32'd1);
    check_val("reg2_full",   rq(2), 32'hDEADBEEF);
    drain();

    // W first with partial strobe
    do_write(32'h8, 32'h11223344, 4'b0101, 2, 0);
    drain();
    check_val("reg2_partial", rq(2), 32'hDE22BE44);

    // Out of range, unaligned in range, zero strobe in range
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_write(32'h16, 32'hCAFEF00D, 4'hF, 0, 1);
    do_write(32'h18, 32'h55555555, 4'h0, 1, 0);
    drain();
    check_bank("bank_oor");

    // B backpressure: second write held until the first response is taken
    bready = 1'b0;
    do_write(32'hC, 32'hA5A5A5A5, 4'hF, 0, 0);
    old4 = model[4];
    do_write(32'h10, 32'h12345678, 4'hF, 0, 0);
    repeat (10) @(negedge clk);
    check_val("bp_awready", {31'd0, awready}, 32'd0);
    check_val("bp_wready",  {31'd0, wready},  32'd0);
    check_val("bp_bvalid",  {31'd0, bvalid},  32'd1);
    check_val("bp_reg4",    rq(4), old4);
    check_val("bp_reg3",    rq(3), 32'hA5A5A5A5);
    sync();
    bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_b2b_bvalid", {31'd0, bvalid}, 32'd1);
    check_val("bp_reg4_new",   rq(4), 32'h12345678);
    drain();

    // Throughput: eight writes with AW and W together
    b_times.delete();
    for (int i = 0; i < 8; i++) do_write(32'(i * 4), 32'h0F000000 + 32'(i * 32'h01010101), 4'hF, 0, 0);
    drain();
    check_val("tp_count", 32'(b_times.size()), 32'd8);
    if (b_times.size() == 8) check_val("tp_spacing", 32'(b_times[7] - b_times[0]), 32'd14);
    check_bank("tp_bank");

    // Asynchronous reset with AW held
    send_aw(32'h20, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("ar_awready", {31'd0, awready}, 32'd1);
    check_val("ar_bvalid",  {31'd0, bvalid},  32'd0);
    for (int k = 0; k < NREG; k++) model[k] = '0;
    check_bank("ar_reg");
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    send_w(32'h87654321, 4'hF, 0);
    repeat (5) @(negedge clk);
    check_val("ar_lone_w_wready", {31'd0, wready}, 32'd0);
    check_val("ar_lone_w_bvalid", {31'd0, bvalid}, 32'd0);
    check_bank("ar_lone_w_reg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
